// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I-subset core: FSM states, opcodes, mux selects.
// Imported by the control FSM, datapath and ALU control so every block agrees on the encodings.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_LOAD_WB   = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_HALT      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   // Wide enough for the largest supported wait limit (255).
   localparam int WAIT_CNT_W = 8;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; tc_o flags the last permitted wait cycle.
// Updates every cycle; clear has priority over enable.
module mem_wait_timer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + WAIT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A further not-ready cycle now would be the MEM_WAIT_MAX-th one.
   assign tc_o = (cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle datapath: 3-5 cycles per instruction plus one per memory wait cycle.
// Stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready_i; halts on illegal opcode or wait timeout.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16,
   parameter int RETIRE_W     = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [6:0]          opcode_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                pc_write_cond_o,
   output logic                pc_source_o,
   output logic                iord_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                ir_write_o,
   output logic                reg_write_o,
   output logic                mem_to_reg_o,
   output logic [1:0]          alu_src_a_o,
   output logic [1:0]          alu_src_b_o,
   output logic [1:0]          alu_op_o,
   output logic                illegal_o,
   output logic                fault_o,
   output logic [RETIRE_W-1:0] retired_o,
   output logic [3:0]          state_o
);

   state_t              state_q, state_d;
   logic                illegal_q, illegal_d;
   logic                fault_q, fault_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                retire;
   logic                wait_tc;
   logic                state_chg;
   logic                waiting;

   assign state_chg = (state_d != state_q);
   assign waiting   = is_mem_state(state_q) && !mem_ready_i;

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_wait_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (state_chg),
      .en_i  (waiting),
      .tc_o  (wait_tc)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      fault_d   = fault_q;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready_i) begin
               state_d = S_DECODE;
            end else if (wait_tc) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode_i)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: state_d = (opcode_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (mem_ready_i) begin
               state_d = S_LOAD_WB;
            end else if (wait_tc) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end
         end
         S_LOAD_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_WRITE: begin
            if (mem_ready_i) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (wait_tc) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
         S_ALU_WB, S_BRANCH: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      retired_d = retire ? (retired_q + RETIRE_W'(1)) : retired_q;
   end

   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_source_o     = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_write_o     = 1'b0;
      mem_to_reg_o    = 1'b0;
      alu_src_a_o     = SRCA_PC;
      alu_src_b_o     = SRCB_RS2;
      alu_op_o        = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         // Branch target PC_old + imm lands in ALUOut for the BRANCH cycle.
         S_DECODE: begin
            alu_src_a_o = SRCA_OLDPC;
            alu_src_b_o = SRCB_IMM;
         end
         S_MEM_ADDR: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
         end
         S_MEM_READ: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         S_LOAD_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a_o = SRCA_RS1;
            alu_op_o    = ALUOP_RTYPE;
         end
         S_EXEC_I: begin
            alu_src_a_o = SRCA_RS1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_ITYPE;
         end
         S_ALU_WB: reg_write_o = 1'b1;
         S_BRANCH: begin
            alu_src_a_o     = SRCA_RS1;
            alu_op_o        = ALUOP_BRANCH;
            pc_write_cond_o = 1'b1;
            pc_source_o     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign illegal_o = illegal_q;
   assign fault_o   = fault_q;
   assign retired_o = retired_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Drives instruction-level scenarios (opcode + wait counts) and checks every cycle against the expected
// state walk derived from the instruction class, with directed cases first and a random mix after.
module tb_multicycle_control;
   import cpu_ctrl_pkg::*;

   localparam int MAXW = 4;
   localparam int RW   = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    opcode;
   logic          mem_ready;
   logic          pc_write_o, pc_write_cond_o, pc_source_o, iord_o;
   logic          mem_read_o, mem_write_o, ir_write_o, reg_write_o, mem_to_reg_o;
   logic [1:0]    alu_src_a_o, alu_src_b_o, alu_op_o;
   logic          illegal_o, fault_o;
   logic [RW-1:0] retired_o;
   logic [3:0]    state_o;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [RW-1:0] exp_ret;
   logic          exp_ill, exp_flt;

   multicycle_control #(.MEM_WAIT_MAX(MAXW), .RETIRE_W(RW)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .opcode_i        (opcode),
      .mem_ready_i     (mem_ready),
      .pc_write_o      (pc_write_o),
      .pc_write_cond_o (pc_write_cond_o),
      .pc_source_o     (pc_source_o),
      .iord_o          (iord_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .ir_write_o      (ir_write_o),
      .reg_write_o     (reg_write_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .alu_src_a_o     (alu_src_a_o),
      .alu_src_b_o     (alu_src_b_o),
      .alu_op_o        (alu_op_o),
      .illegal_o       (illegal_o),
      .fault_o         (fault_o),
      .retired_o       (retired_o),
      .state_o         (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] junk_op();
      return 7'($urandom);
   endfunction

   function automatic logic [6:0] illegal_op();
      logic [6:0] o;
      do o = 7'($urandom);
      while (o == OP_LOAD || o == OP_STORE || o == OP_RTYPE || o == OP_ITYPE || o == OP_BRANCH);
      return o;
   endfunction

   // {ALUSrcA, ALUSrcB, ALUOp} each state must present.
   function automatic logic [5:0] exp_sel(input state_t s);
      case (s)
         S_FETCH:    return 6'b00_01_00;
         S_DECODE:   return 6'b01_10_00;
         S_MEM_ADDR: return 6'b10_10_00;
         S_EXEC_R:   return 6'b10_00_10;
         S_EXEC_I:   return 6'b10_10_11;
         S_BRANCH:   return 6'b10_00_01;
         default:    return 6'b00_00_00;
      endcase
   endfunction

   function automatic int pick_waits();
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) return 0;
      if (r < 14) return 1;
      if (r < 17) return 2;
      if (r < 19) return MAXW - 1;
      return MAXW;
   endfunction

   // One clock cycle the model expects to be spent in state es.
   task automatic cyc(input state_t es, input logic rdy, input logic [6:0] opc, input bit retires);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = opc;
      #1;
      chk("state", state_o, es);
      chk("mem_read", mem_read_o, (es == S_FETCH) || (es == S_MEM_READ));
      chk("iord", iord_o, (es == S_MEM_READ) || (es == S_MEM_WRITE));
      chk("mem_write", mem_write_o, es == S_MEM_WRITE);
      chk("ir_write", ir_write_o, (es == S_FETCH) && rdy);
      chk("pc_write", pc_write_o, (es == S_FETCH) && rdy);
      chk("pc_cond_src", {pc_write_cond_o, pc_source_o}, (es == S_BRANCH) ? 2'b11 : 2'b00);
      chk("reg_wb", {reg_write_o, mem_to_reg_o},
          (es == S_LOAD_WB) ? 2'b11 : ((es == S_ALU_WB) ? 2'b10 : 2'b00));
      chk("alu_sel", {alu_src_a_o, alu_src_b_o, alu_op_o}, exp_sel(es));
      chk("retired", retired_o, exp_ret);
      chk("illegal", illegal_o, exp_ill);
      chk("fault", fault_o, exp_flt);
      if (retires) exp_ret = exp_ret + 1'b1;
   endtask

   task automatic mem_phase(input state_t st, input int waits, input bit retire_on_done,
                            output bit timed_out);
      timed_out = 1'b0;
      for (int i = 0; i < waits && i < MAXW; i++) cyc(st, 1'b0, junk_op(), 1'b0);
      if (waits >= MAXW) begin
         timed_out = 1'b1;
         exp_flt   = 1'b1;
      end else begin
         cyc(st, 1'b1, junk_op(), retire_on_done);
      end
   endtask

   task automatic run_instr(input logic [6:0] opc, input int wf, input int wm, output bit halted);
      bit to;
      halted = 1'b0;
      mem_phase(S_FETCH, wf, 1'b0, to);
      if (to) begin
         halted = 1'b1;
         return;
      end
      cyc(S_DECODE, 1'($urandom), opc, 1'b0);
      if (opc == OP_LOAD) begin
         cyc(S_MEM_ADDR, 1'($urandom), opc, 1'b0);
         mem_phase(S_MEM_READ, wm, 1'b0, to);
         if (to) halted = 1'b1;
         else    cyc(S_LOAD_WB, 1'($urandom), junk_op(), 1'b1);
      end else if (opc == OP_STORE) begin
         cyc(S_MEM_ADDR, 1'($urandom), opc, 1'b0);
         mem_phase(S_MEM_WRITE, wm, 1'b1, to);
         halted = to;
      end else if (opc == OP_RTYPE) begin
         cyc(S_EXEC_R, 1'($urandom), junk_op(), 1'b0);
         cyc(S_ALU_WB, 1'($urandom), junk_op(), 1'b1);
      end else if (opc == OP_ITYPE) begin
         cyc(S_EXEC_I, 1'($urandom), junk_op(), 1'b0);
         cyc(S_ALU_WB, 1'($urandom), junk_op(), 1'b1);
      end else if (opc == OP_BRANCH) begin
         cyc(S_BRANCH, 1'($urandom), junk_op(), 1'b1);
      end else begin
         exp_ill = 1'b1;
         halted  = 1'b1;
      end
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(S_HALT, 1'($urandom), junk_op(), 1'b0);
   endtask

   // Two reset edges; the next cyc() lands on the first FETCH cycle.
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'($urandom);
      opcode    = junk_op();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      exp_ret = '0;
      exp_ill = 1'b0;
      exp_flt = 1'b0;
   endtask

   initial begin
      bit h;
      int r;
      logic [6:0] opc;
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = '0;
      exp_ret   = '0;
      exp_ill   = 1'b0;
      exp_flt   = 1'b0;
      do_reset();

      // I-type with ready memory, then a load with three MEM_READ wait cycles, then a branch.
      run_instr(OP_ITYPE, 0, 0, h);
      run_instr(OP_LOAD, 0, 3, h);
      run_instr(OP_BRANCH, 0, 0, h);
      run_instr(OP_RTYPE, 1, 0, h);
      run_instr(OP_STORE, 0, MAXW - 1, h);

      // Illegal opcode: HALT holds for 10 cycles even with ready memory; reset clears Illegal.
      run_instr(7'b1111111, 0, 0, h);
      for (int i = 0; i < 10; i++) cyc(S_HALT, 1'b1, junk_op(), 1'b0);
      do_reset();

      // Store timeout after MAXW not-ready MEM_WRITE cycles.
      run_instr(OP_STORE, 0, MAXW, h);
      halt_cycles(3);
      do_reset();

      // Reset asserted while a store is waiting in MEM_WRITE.
      cyc(S_FETCH, 1'b1, junk_op(), 1'b0);
      cyc(S_DECODE, 1'b1, OP_STORE, 1'b0);
      cyc(S_MEM_ADDR, 1'b1, OP_STORE, 1'b0);
      cyc(S_MEM_WRITE, 1'b0, junk_op(), 1'b0);
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(S_FETCH, 1'b0, junk_op(), 1'b0);
      do_reset();

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 19);
         if      (r < 4)  opc = OP_LOAD;
         else if (r < 8)  opc = OP_STORE;
         else if (r < 12) opc = OP_RTYPE;
         else if (r < 16) opc = OP_ITYPE;
         else if (r < 19) opc = OP_BRANCH;
         else             opc = illegal_op();
         run_instr(opc, pick_waits(), pick_waits(), h);
         if (h) begin
            halt_cycles($urandom_range(1, 4));
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
